// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS-subset control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing
// with combinational strobes and datapath selects derived from state and instruction.
module mips_multicycle_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] instr_i,
  input  logic        mem_ready_i,
  input  logic        zero_i,
  output logic [2:0]  state_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic        mem_addr_sel_o,
  output logic        ir_we_o,
  output logic        pc_we_o,
  output logic [1:0]  pc_src_o,
  output logic        rf_we_o,
  output logic [1:0]  rd_addr_sel_o,
  output logic [1:0]  src_rd_data_o,
  output logic [3:0]  alu_op_o,
  output logic        alu_operand_b_o,
  output logic        illegal_o,
  output logic        retired_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic [5:0] opcode, funct;
  logic [4:0] shamt, rt, rd;
  logic is_r, is_jr, is_lw, is_sw, is_beq, is_bne, is_addi, is_andi, is_j, is_jal;
  logic legal_exec;
  logic unused_rs;

  assign opcode    = instr_i[31:26];
  assign funct     = instr_i[5:0];
  assign shamt     = instr_i[10:6];
  assign rt        = instr_i[20:16];
  assign rd        = instr_i[15:11];
  assign unused_rs = ^instr_i[25:21];

  always_comb begin
    is_r = 1'b0;
    if (opcode == 6'h00 && shamt == 5'd0) begin
      case (funct)
        6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: is_r = 1'b1;
        default:                           is_r = 1'b0;
      endcase
    end
  end

  assign is_jr      = (opcode == 6'h00) && (rt == 5'd0) && (rd == 5'd0) &&
                      (shamt == 5'd0) && (funct == 6'h08);
  assign is_lw      = (opcode == 6'h23);
  assign is_sw      = (opcode == 6'h2B);
  assign is_beq     = (opcode == 6'h04);
  assign is_bne     = (opcode == 6'h05);
  assign is_addi    = (opcode == 6'h08);
  assign is_andi    = (opcode == 6'h0C);
  assign is_j       = (opcode == 6'h02);
  assign is_jal     = (opcode == 6'h03);
  assign legal_exec = is_r | is_lw | is_sw | is_beq | is_bne | is_addi | is_andi;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  assign state_o = state_q;

  always_comb begin
    state_d         = S_FETCH;
    mem_req_o       = 1'b0;
    mem_we_o        = 1'b0;
    mem_addr_sel_o  = 1'b0;
    ir_we_o         = 1'b0;
    pc_we_o         = 1'b0;
    pc_src_o        = 2'd0;
    rf_we_o         = 1'b0;
    rd_addr_sel_o   = 2'd0;
    src_rd_data_o   = 2'd0;
    alu_op_o        = 4'h0;
    alu_operand_b_o = 1'b0;
    illegal_o       = 1'b0;
    retired_o       = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req_o = 1'b1;
        if (mem_ready_i) begin
          ir_we_o = 1'b1;
          pc_we_o = 1'b1;
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        if (is_j || is_jal) begin
          pc_we_o   = 1'b1;
          pc_src_o  = 2'd2;
          retired_o = 1'b1;
          if (is_jal) begin
            rf_we_o       = 1'b1;
            rd_addr_sel_o = 2'd2;
            src_rd_data_o = 2'd2;
          end
        end else if (is_jr) begin
          pc_we_o   = 1'b1;
          pc_src_o  = 2'd3;
          retired_o = 1'b1;
        end else if (legal_exec) begin
          state_d = S_EXEC;
        end else begin
          illegal_o = 1'b1;
        end
      end
      S_EXEC: begin
        if (is_r)                 alu_op_o = funct[3:0];
        else if (is_andi)         alu_op_o = 4'h4;
        else if (is_beq | is_bne) alu_op_o = 4'h2;
        alu_operand_b_o = is_r | is_beq | is_bne;
        if (is_beq || is_bne) begin
          pc_src_o  = 2'd1;
          pc_we_o   = (is_beq & zero_i) | (is_bne & ~zero_i);
          retired_o = 1'b1;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_req_o      = 1'b1;
        mem_addr_sel_o = 1'b1;
        mem_we_o       = is_sw;
        if (!mem_ready_i)  state_d = S_MEM;
        else if (is_sw)    retired_o = 1'b1;
        else               state_d = S_WB;
      end
      S_WB: begin
        rf_we_o   = 1'b1;
        retired_o = 1'b1;
        if (is_lw) begin
          rd_addr_sel_o = 2'd1;
          src_rd_data_o = 2'd1;
        end else if (!is_r) begin
          rd_addr_sel_o = 2'd1;
        end
      end
      default: state_d = S_FETCH;
    endcase

    // Reset abandons any in-flight access immediately, so strobes drop this cycle.
    if (rst_i) begin
      mem_req_o = 1'b0;
      mem_we_o  = 1'b0;
      ir_we_o   = 1'b0;
      pc_we_o   = 1'b0;
      rf_we_o   = 1'b0;
      illegal_o = 1'b0;
      retired_o = 1'b0;
    end
  end

endmodule
